// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage for the RV64IM pipeline.
// Keeps the fetch PC and has at most one instruction-memory request in flight.
// Each returned word goes through a static predictor: JAL and backward
// conditional branches are predicted taken, everything else falls through.
// Fetched entries are queued toward decode. A redirect from execute flushes
// the whole stage.
// DEPTH must be a power of two and at least 2, so the FIFO pointers wrap
// naturally.

module fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req_valid,
  output logic [63:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        dec_ready,
  output logic        dec_valid,
  output logic [31:0] instruction,
  output logic [63:0] pc,
  output logic        branch_taken
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  state_t          r_state;
  logic [63:0]     r_pc;
  logic            r_active;
  logic [PW-1:0]   r_wrPtr;
  logic [PW-1:0]   r_rdPtr;
  logic [CW-1:0]   r_count;
  logic [31:0]     r_instMem  [DEPTH];
  logic [63:0]     r_pcMem    [DEPTH];
  logic            r_takenMem [DEPTH];

  logic [6:0]      w_opcode;
  logic [63:0]     w_immJ;
  logic [63:0]     w_immB;
  logic            w_isJal;
  logic            w_isBackBranch;
  logic            w_taken;
  logic [63:0]     w_nextPc;
  logic            w_reqFire;
  logic            w_push;
  logic            w_pop;

  // Pre-decode of the returning word: sign-extended J/B immediates and the static prediction.
  always_comb begin
    w_opcode       = imem_resp_data[6:0];
    w_immJ         = {{44{imem_resp_data[31]}}, imem_resp_data[19:12], imem_resp_data[20],
                      imem_resp_data[30:21], 1'b0};
    w_immB         = {{52{imem_resp_data[31]}}, imem_resp_data[7], imem_resp_data[30:25],
                      imem_resp_data[11:8], 1'b0};
    w_isJal        = (w_opcode == OPC_JAL);
    w_isBackBranch = (w_opcode == OPC_BRANCH) && imem_resp_data[31];
    w_taken        = w_isJal || w_isBackBranch;
    if (w_isJal) begin
      w_nextPc = r_pc + w_immJ;
    end else if (w_isBackBranch) begin
      w_nextPc = r_pc + w_immB;
    end else begin
      w_nextPc = r_pc + 64'd4;
    end
  end

  // Request admission and FIFO handshakes. The request is only raised in FETCH,
  // where nothing is in flight, so count < DEPTH already reserves the slot for
  // the response. A redirect suppresses every handshake in its cycle.
  // r_active keeps the request low in the cycle that reset is released.
  always_comb begin
    imem_req_valid = r_active && (r_state == S_FETCH) && (r_count < DEPTH_C) && !redirect_valid;
    imem_req_addr  = r_pc;
    w_reqFire      = imem_req_valid && imem_req_ready;
    w_push         = (r_state == S_WAIT) && imem_resp_valid && !redirect_valid;
    dec_valid      = (r_count != '0);
    w_pop          = dec_valid && dec_ready && !redirect_valid;
  end

  // The head entry is read straight out of storage.
  always_comb begin
    instruction  = r_instMem[r_rdPtr];
    pc           = r_pcMem[r_rdPtr];
    branch_taken = r_takenMem[r_rdPtr];
  end

  // Fetch state machine and fetch PC. The PC moves only on a redirect or a push,
  // which keeps the request address stable while a request waits for ready.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_FETCH;
      r_pc     <= RESET_PC;
      r_active <= 1'b0;
    end else begin
      r_active <= 1'b1;
      if (redirect_valid) begin
        r_pc <= redirect_pc;
        case (r_state)
          S_WAIT:  r_state <= imem_resp_valid ? S_FETCH : S_DROP;
          S_DROP:  r_state <= imem_resp_valid ? S_FETCH : S_DROP;
          default: r_state <= S_FETCH;
        endcase
      end else begin
        case (r_state)
          S_FETCH: begin
            if (w_reqFire) begin
              r_state <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (imem_resp_valid) begin
              r_pc    <= w_nextPc;
              r_state <= S_FETCH;
            end
          end
          S_DROP: begin
            if (imem_resp_valid) begin
              r_state <= S_FETCH;
            end
          end
          default: r_state <= S_FETCH;
        endcase
      end
    end
  end

  // FIFO pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (redirect_valid) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage: a push writes {word, fetch PC, prediction} at the tail.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_instMem[i]  <= '0;
        r_pcMem[i]    <= '0;
        r_takenMem[i] <= 1'b0;
      end
    end else if (w_push) begin
      r_instMem[r_wrPtr]  <= imem_resp_data;
      r_pcMem[r_wrPtr]    <= r_pc;
      r_takenMem[r_wrPtr] <= w_taken;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios for fetch_unit with a one-request memory
// model whose latency can be changed per scenario.

module tb_fetch_unit;

  localparam logic [31:0] ADDI_WORD = 32'h00108093;
  localparam logic [63:0] BAD_VAL   = 64'hBAD0_BAD0_BAD0_BAD0;

  localparam logic [63:0] BR_TARGET [6] = '{64'h2000, 64'h3000, 64'h3000, 64'h5000, 64'h6000,
                                            64'hFFFF_FFFF_FFFF_FFFC};
  localparam logic [63:0] BR_NEXT   [6] = '{64'h2040, 64'h2FF8, 64'h3004, 64'h4FFC, 64'h6004,
                                            64'h0};
  localparam logic [31:0] BR_INST   [6] = '{32'h0400006F, 32'hFE000CE3, 32'h00000863,
                                            32'hFFDFF06F, 32'h00008067, 32'h00108093};
  localparam logic        BR_TAKEN  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic        BR_FWD    [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  logic        clk;
  logic        reset_n;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        dec_ready;
  logic        dec_valid;
  logic [31:0] instruction;
  logic [63:0] pc;
  logic        branch_taken;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int memLatency = 1;
  int memCount = 0;
  bit pending = 1'b0;
  bit fwdMode = 1'b0;
  logic [63:0] pendAddr;

  logic        sReqValid, sDecValid, sRespValid, sTaken;
  logic [63:0] sReqAddr, sPc;
  logic [31:0] sInst;

  logic [63:0] reqLog[$];
  logic [63:0] popPcLog[$];
  logic [31:0] popInstLog[$];
  logic        popTakenLog[$];
  int          popCycLog[$];

  fetch_unit #(.DEPTH(4), .RESET_PC(64'h1000)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .dec_ready       (dec_ready),
    .dec_valid       (dec_valid),
    .instruction     (instruction),
    .pc              (pc),
    .branch_taken    (branch_taken)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a scenario wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Instruction memory contents; anything not listed is an ADDI.
  function automatic logic [31:0] memWord(input logic [63:0] a);
    case (a)
      64'h2000: return 32'h0400006F;
      64'h3000: return fwdMode ? 32'h00000863 : 32'hFE000CE3;
      64'h5000: return 32'hFFDFF06F;
      64'h6000: return 32'h00008067;
      default:  return ADDI_WORD;
    endcase
  endfunction

  function automatic logic [63:0] reqAt(input int i);
    if (i < reqLog.size()) return reqLog[i];
    return BAD_VAL;
  endfunction

  function automatic logic [63:0] popPcAt(input int i);
    if (i < popPcLog.size()) return popPcLog[i];
    return BAD_VAL;
  endfunction

  function automatic logic [31:0] popInstAt(input int i);
    if (i < popInstLog.size()) return popInstLog[i];
    return 32'hBAD0BAD0;
  endfunction

  function automatic logic popTakenAt(input int i);
    if (i < popTakenLog.size()) return popTakenLog[i];
    return 1'b1;
  endfunction

  task automatic clearLogs();
    reqLog.delete();
    popPcLog.delete();
    popInstLog.delete();
    popTakenLog.delete();
    popCycLog.delete();
  endtask

  // One clock cycle: sample and log handshakes mid-cycle, then after the edge
  // advance the memory model and drive its response for the new cycle.
  task automatic applyStimulus();
    @(negedge clk);
    sReqValid  = imem_req_valid;
    sReqAddr   = imem_req_addr;
    sDecValid  = dec_valid;
    sPc        = pc;
    sInst      = instruction;
    sTaken     = branch_taken;
    sRespValid = imem_resp_valid;
    if (reset_n && imem_req_valid && imem_req_ready) begin
      reqLog.push_back(imem_req_addr);
      pending  = 1'b1;
      pendAddr = imem_req_addr;
      memCount = memLatency;
    end
    if (reset_n && dec_valid && dec_ready && !redirect_valid) begin
      popPcLog.push_back(pc);
      popInstLog.push_back(instruction);
      popTakenLog.push_back(branch_taken);
      popCycLog.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    if (pending) begin
      memCount--;
      if (memCount <= 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = memWord(pendAddr);
        pending         = 1'b0;
      end
    end
  endtask

  task automatic redirectTo(input logic [63:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    applyStimulus();
    redirect_valid = 1'b0;
  endtask

  task automatic doReset();
    reset_n         = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    dec_ready       = 1'b1;
    imem_req_ready  = 1'b1;
    pending         = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    memLatency      = 1;
    fwdMode         = 1'b0;
    repeat (3) applyStimulus();
    reset_n = 1'b1;
    clearLogs();
    cyc = 0;
  endtask

  // Outputs while reset is held, then the first request timing after release.
  task automatic test_reset();
    reset_n         = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    dec_ready       = 1'b1;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    repeat (2) applyStimulus();
    checks++;
    if (sReqValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_valid: got %b expected 0", sReqValid); end
    checks++;
    if (sReqAddr !== 64'h1000) begin errors++; $display("[TB] FAIL reset_req_addr: got %h expected 1000", sReqAddr); end
    checks++;
    if (sDecValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_dec_valid: got %b expected 0", sDecValid); end
    checks++;
    if (sInst !== 32'h0) begin errors++; $display("[TB] FAIL reset_instruction: got %h expected 0", sInst); end
    checks++;
    if (sPc !== 64'h0) begin errors++; $display("[TB] FAIL reset_pc: got %h expected 0", sPc); end
    checks++;
    if (sTaken !== 1'b0) begin errors++; $display("[TB] FAIL reset_taken: got %b expected 0", sTaken); end
    reset_n = 1'b1;
    clearLogs();
    applyStimulus();
    checks++;
    if (sReqValid !== 1'b0) begin errors++; $display("[TB] FAIL release_cycle0_req: got %b expected 0", sReqValid); end
    applyStimulus();
    checks++;
    if (sReqValid !== 1'b1) begin errors++; $display("[TB] FAIL release_cycle1_req: got %b expected 1", sReqValid); end
    checks++;
    if (sReqAddr !== 64'h1000) begin errors++; $display("[TB] FAIL release_cycle1_addr: got %h expected 1000", sReqAddr); end
  endtask

  // Straight-line ADDI stream with a one-cycle memory: one entry every two cycles.
  task automatic test_sequential();
    doReset();
    repeat (10) applyStimulus();
    checks++;
    if (reqLog.size() != 5) begin errors++; $display("[TB] FAIL seq_req_count: got %0d expected 5", reqLog.size()); end
    checks++;
    if (popPcLog.size() != 4) begin errors++; $display("[TB] FAIL seq_pop_count: got %0d expected 4", popPcLog.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (reqAt(i) !== 64'h1000 + 64'(4 * i)) begin
        errors++; $display("[TB] FAIL seq_req_addr[%0d]: got %h expected %h", i, reqAt(i), 64'h1000 + 64'(4 * i));
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (popPcAt(i) !== 64'h1000 + 64'(4 * i)) begin
        errors++; $display("[TB] FAIL seq_pop_pc[%0d]: got %h expected %h", i, popPcAt(i), 64'h1000 + 64'(4 * i));
      end
      checks++;
      if (popInstAt(i) !== ADDI_WORD) begin
        errors++; $display("[TB] FAIL seq_pop_inst[%0d]: got %h expected %h", i, popInstAt(i), ADDI_WORD);
      end
      checks++;
      if (popTakenAt(i) !== 1'b0) begin
        errors++; $display("[TB] FAIL seq_pop_taken[%0d]: got %b expected 0", i, popTakenAt(i));
      end
    end
    checks++;
    if (popCycLog.size() < 4 || popCycLog[0] != 3) begin
      errors++; $display("[TB] FAIL seq_first_pop_cycle: got %0d expected 3", (popCycLog.size() > 0) ? popCycLog[0] : -1);
    end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (popCycLog.size() < 4 || popCycLog[i] - popCycLog[i-1] != 2) begin
        errors++; $display("[TB] FAIL seq_pop_spacing[%0d]: got %0d expected 2", i,
                           (popCycLog.size() > i) ? popCycLog[i] - popCycLog[i-1] : -1);
      end
    end
  endtask

  // Predictor vectors: JAL +0x40, backward branch -8, forward branch +16,
  // JAL -4, JALR, and PC wrap-around at the top of the address space.
  task automatic test_branches();
    dec_ready      = 1'b1;
    imem_req_ready = 1'b1;
    memLatency     = 1;
    for (int i = 0; i < 6; i++) begin
      fwdMode = BR_FWD[i];
      redirectTo(BR_TARGET[i]);
      clearLogs();
      repeat (8) applyStimulus();
      checks++;
      if (reqLog.size() < 2 || popPcLog.size() < 2) begin
        errors++; $display("[TB] FAIL br_counts[%0d]: got req=%0d pop=%0d expected at least 2 each", i, reqLog.size(), popPcLog.size());
      end
      checks++;
      if (reqAt(0) !== BR_TARGET[i]) begin
        errors++; $display("[TB] FAIL br_first_req[%0d]: got %h expected %h", i, reqAt(0), BR_TARGET[i]);
      end
      checks++;
      if (reqAt(1) !== BR_NEXT[i]) begin
        errors++; $display("[TB] FAIL br_next_req[%0d]: got %h expected %h", i, reqAt(1), BR_NEXT[i]);
      end
      checks++;
      if (popPcAt(0) !== BR_TARGET[i]) begin
        errors++; $display("[TB] FAIL br_pop_pc[%0d]: got %h expected %h", i, popPcAt(0), BR_TARGET[i]);
      end
      checks++;
      if (popInstAt(0) !== BR_INST[i]) begin
        errors++; $display("[TB] FAIL br_pop_inst[%0d]: got %h expected %h", i, popInstAt(0), BR_INST[i]);
      end
      checks++;
      if (popTakenAt(0) !== BR_TAKEN[i]) begin
        errors++; $display("[TB] FAIL br_pop_taken[%0d]: got %b expected %b", i, popTakenAt(0), BR_TAKEN[i]);
      end
      checks++;
      if (popPcAt(1) !== BR_NEXT[i]) begin
        errors++; $display("[TB] FAIL br_second_pop_pc[%0d]: got %h expected %h", i, popPcAt(1), BR_NEXT[i]);
      end
    end
    fwdMode = 1'b0;
  endtask

  // Decode stalled: exactly DEPTH requests, then in-order drain and resume.
  task automatic test_stall();
    dec_ready      = 1'b0;
    imem_req_ready = 1'b1;
    memLatency     = 1;
    redirectTo(64'hA000);
    clearLogs();
    repeat (20) applyStimulus();
    checks++;
    if (reqLog.size() != 4) begin errors++; $display("[TB] FAIL stall_req_count: got %0d expected 4", reqLog.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (reqAt(i) !== 64'hA000 + 64'(4 * i)) begin
        errors++; $display("[TB] FAIL stall_req_addr[%0d]: got %h expected %h", i, reqAt(i), 64'hA000 + 64'(4 * i));
      end
    end
    checks++;
    if (sReqValid !== 1'b0) begin errors++; $display("[TB] FAIL stall_req_valid_low: got %b expected 0", sReqValid); end
    checks++;
    if (sDecValid !== 1'b1) begin errors++; $display("[TB] FAIL stall_dec_valid: got %b expected 1", sDecValid); end
    dec_ready = 1'b1;
    clearLogs();
    repeat (12) applyStimulus();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (popPcAt(i) !== 64'hA000 + 64'(4 * i)) begin
        errors++; $display("[TB] FAIL stall_drain_pc[%0d]: got %h expected %h", i, popPcAt(i), 64'hA000 + 64'(4 * i));
      end
    end
    checks++;
    if (reqAt(0) !== 64'hA010) begin errors++; $display("[TB] FAIL stall_resume_addr: got %h expected a010", reqAt(0)); end
  endtask

  // Redirect one cycle after a handshake with a 3-cycle memory: the late response is dropped.
  task automatic test_redirect_drop();
    memLatency     = 3;
    imem_req_ready = 1'b0;
    dec_ready      = 1'b1;
    redirectTo(64'h7000);
    repeat (6) applyStimulus();
    imem_req_ready = 1'b1;
    clearLogs();
    applyStimulus();
    checks++;
    if (sReqValid !== 1'b1 || sReqAddr !== 64'h7000) begin
      errors++; $display("[TB] FAIL drop_handshake: got valid=%b addr=%h expected valid=1 addr=7000", sReqValid, sReqAddr);
    end
    redirectTo(64'h8000);
    checks++;
    if (sReqValid !== 1'b0) begin errors++; $display("[TB] FAIL drop_no_req_redirect: got %b expected 0", sReqValid); end
    applyStimulus();
    checks++;
    if (sReqValid !== 1'b0) begin errors++; $display("[TB] FAIL drop_no_req_waiting: got %b expected 0", sReqValid); end
    applyStimulus();
    checks++;
    if (sRespValid !== 1'b1) begin errors++; $display("[TB] FAIL drop_resp_arrives: got %b expected 1", sRespValid); end
    checks++;
    if (sReqValid !== 1'b0) begin errors++; $display("[TB] FAIL drop_no_req_on_resp: got %b expected 0", sReqValid); end
    clearLogs();
    applyStimulus();
    checks++;
    if (sDecValid !== 1'b0) begin errors++; $display("[TB] FAIL drop_fifo_empty: got %b expected 0", sDecValid); end
    checks++;
    if (sReqValid !== 1'b1 || sReqAddr !== 64'h8000) begin
      errors++; $display("[TB] FAIL drop_next_req: got valid=%b addr=%h expected valid=1 addr=8000", sReqValid, sReqAddr);
    end
    repeat (6) applyStimulus();
    checks++;
    if (popPcAt(0) !== 64'h8000) begin errors++; $display("[TB] FAIL drop_first_pop_pc: got %h expected 8000", popPcAt(0)); end
  endtask

  // Redirect, response and pop all in one cycle.
  task automatic test_redirect_same_cycle();
    bit found;
    memLatency     = 1;
    imem_req_ready = 1'b1;
    dec_ready      = 1'b0;
    redirectTo(64'hC000);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      applyStimulus();
      found = imem_resp_valid && dec_valid;
    end
    checks++;
    if (!found) begin errors++; $display("[TB] FAIL same_setup: got no resp+entry cycle expected one within 20 cycles"); end
    dec_ready = 1'b1;
    redirectTo(64'h9000);
    clearLogs();
    applyStimulus();
    checks++;
    if (sDecValid !== 1'b0) begin errors++; $display("[TB] FAIL same_fifo_flushed: got %b expected 0", sDecValid); end
    checks++;
    if (sReqValid !== 1'b1 || sReqAddr !== 64'h9000) begin
      errors++; $display("[TB] FAIL same_req_next: got valid=%b addr=%h expected valid=1 addr=9000", sReqValid, sReqAddr);
    end
    repeat (4) applyStimulus();
    checks++;
    if (popPcAt(0) !== 64'h9000) begin errors++; $display("[TB] FAIL same_first_pop_pc: got %h expected 9000", popPcAt(0)); end
  endtask

  // Asynchronous reset while waiting on memory with two entries queued.
  task automatic test_reset_midflight();
    memLatency     = 3;
    imem_req_ready = 1'b1;
    dec_ready      = 1'b0;
    redirectTo(64'hB000);
    clearLogs();
    for (int k = 0; k < 40 && reqLog.size() < 3; k++) applyStimulus();
    checks++;
    if (reqLog.size() != 3) begin errors++; $display("[TB] FAIL mid_setup_reqs: got %0d expected 3", reqLog.size()); end
    checks++;
    if (dec_valid !== 1'b1 || pc !== 64'hB000) begin
      errors++; $display("[TB] FAIL mid_setup_head: got valid=%b pc=%h expected valid=1 pc=b000", dec_valid, pc);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (dec_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_async_dec_valid: got %b expected 0", dec_valid); end
    checks++;
    if (imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_async_req_valid: got %b expected 0", imem_req_valid); end
    checks++;
    if (imem_req_addr !== 64'h1000) begin errors++; $display("[TB] FAIL mid_async_req_addr: got %h expected 1000", imem_req_addr); end
    checks++;
    if (pc !== 64'h0 || instruction !== 32'h0) begin
      errors++; $display("[TB] FAIL mid_async_head: got pc=%h inst=%h expected 0 and 0", pc, instruction);
    end
    pending         = 1'b0;
    imem_resp_valid = 1'b0;
    dec_ready       = 1'b1;
    repeat (2) applyStimulus();
    reset_n = 1'b1;
    clearLogs();
    applyStimulus();
    checks++;
    if (sReqValid !== 1'b0) begin errors++; $display("[TB] FAIL mid_release_cycle0: got %b expected 0", sReqValid); end
    applyStimulus();
    checks++;
    if (sReqValid !== 1'b1 || sReqAddr !== 64'h1000) begin
      errors++; $display("[TB] FAIL mid_release_first_req: got valid=%b addr=%h expected valid=1 addr=1000", sReqValid, sReqAddr);
    end
  endtask

  // Scenario sequence.
  initial begin
    reset_n         = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    dec_ready       = 1'b1;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    pendAddr        = '0;
    test_reset();
    test_sequential();
    test_branches();
    test_stall();
    test_redirect_drop();
    test_redirect_same_cycle();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
